// File: rtl/fpnew_opgroup_dispatch.sv
// Steers FP ops to opgroup blocks and retires their results in issue order.
// A small order FIFO of opgroup indices decides which group's result may leave next.

module fpnew_opgroup_dispatch_lane #(
  parameter int unsigned GrpW  = 2,
  parameter int unsigned Idx   = 0,
  parameter int unsigned Width = 64,
  parameter type         TagType = logic
) (
  input  logic [GrpW-1:0]  opgrp_i,
  input  logic             issue_en_i,
  input  logic [GrpW-1:0]  head_i,
  input  logic             retire_en_i,
  input  logic             out_ready_i,
  input  logic             grp_out_valid_i,
  input  logic [Width-1:0] grp_result_i,
  input  logic [4:0]       grp_status_i,
  input  TagType           grp_tag_i,
  output logic             grp_in_valid_o,
  output logic             grp_out_ready_o,
  output logic             head_valid_o,
  output logic [Width-1:0] result_o,
  output logic [4:0]       status_o,
  output TagType           tag_o
);
  logic is_head;

  assign grp_in_valid_o  = issue_en_i & (opgrp_i == GrpW'(Idx));
  assign is_head         = retire_en_i & (head_i == GrpW'(Idx));
  assign head_valid_o    = is_head & grp_out_valid_i;
  assign grp_out_ready_o = is_head & out_ready_i;
  // Payload is zeroed unless this lane is the valid head, so the top can OR-merge lanes
  assign result_o        = head_valid_o ? grp_result_i : '0;
  assign status_o        = head_valid_o ? grp_status_i : '0;
  assign tag_o           = head_valid_o ? grp_tag_i : TagType'('0);
endmodule

module fpnew_opgroup_dispatch #(
  parameter int unsigned NumOpGroups = 4,
  parameter int unsigned Width       = 64,
  parameter int unsigned MaxInFlight = 8,
  parameter type         TagType     = logic,
  localparam int unsigned GrpW = $clog2(NumOpGroups),
  localparam int unsigned PtrW = $clog2(MaxInFlight),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [GrpW-1:0]                    opgrp_i,
  output logic [NumOpGroups-1:0]             grp_in_valid_o,
  input  logic [NumOpGroups-1:0]             grp_in_ready_i,
  input  logic [NumOpGroups-1:0]             grp_out_valid_i,
  output logic [NumOpGroups-1:0]             grp_out_ready_o,
  input  logic [NumOpGroups-1:0][Width-1:0]  grp_result_i,
  input  logic [NumOpGroups-1:0][4:0]        grp_status_i,
  input  TagType [NumOpGroups-1:0]           grp_tag_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [Width-1:0]                   result_o,
  output logic [4:0]                         status_o,
  output TagType                             tag_o,
  output logic [CntW-1:0]                    inflight_o,
  output logic                               busy_o
);
  logic [MaxInFlight-1:0][GrpW-1:0] fifo_q;
  logic [PtrW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                  count_q;
  logic                             full, empty, issue_en, push, pop;
  logic [GrpW-1:0]                  head;
  logic [NumOpGroups-1:0]           lane_head_valid;
  logic [NumOpGroups-1:0][Width-1:0] lane_result;
  logic [NumOpGroups-1:0][4:0]      lane_status;
  TagType [NumOpGroups-1:0]         lane_tag;

  assign full     = (count_q == CntW'(MaxInFlight));
  assign empty    = (count_q == '0);
  assign issue_en = in_valid_i & ~full & ~flush_i;
  assign head     = fifo_q[rd_ptr_q];

  for (genvar g = 0; g < NumOpGroups; g++) begin : gen_lane
    fpnew_opgroup_dispatch_lane #(
      .GrpW(GrpW), .Idx(g), .Width(Width), .TagType(TagType)
    ) u_lane (
      .opgrp_i         (opgrp_i),
      .issue_en_i      (issue_en),
      .head_i          (head),
      .retire_en_i     (~empty),
      .out_ready_i     (out_ready_i),
      .grp_out_valid_i (grp_out_valid_i[g]),
      .grp_result_i    (grp_result_i[g]),
      .grp_status_i    (grp_status_i[g]),
      .grp_tag_i       (grp_tag_i[g]),
      .grp_in_valid_o  (grp_in_valid_o[g]),
      .grp_out_ready_o (grp_out_ready_o[g]),
      .head_valid_o    (lane_head_valid[g]),
      .result_o        (lane_result[g]),
      .status_o        (lane_status[g]),
      .tag_o           (lane_tag[g])
    );
  end

  // Out-of-range opgrp_i matches no lane, so the op is never accepted
  assign in_ready_o  = |(grp_in_valid_o & grp_in_ready_i);
  assign out_valid_o = |lane_head_valid;
  assign push        = in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    result_o = '0;
    status_o = '0;
    tag_o    = TagType'('0);
    for (int g = 0; g < NumOpGroups; g++) begin
      result_o = result_o | lane_result[g];
      status_o = status_o | lane_status[g];
      tag_o    = tag_o | lane_tag[g];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= opgrp_i;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign inflight_o = count_q;
  assign busy_o     = |count_q;
endmodule

// File: tb/tb_fpnew_opgroup_dispatch.sv
// Bench for fpnew_opgroup_dispatch: directed scenarios plus random traffic against a queue model.
module tb_fpnew_opgroup_dispatch;
  localparam int NG = 4, W = 64, MIF = 8;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, busy, tag;
  logic [1:0] opgrp;
  logic [NG-1:0] grp_in_valid, grp_in_ready, grp_out_valid, grp_out_ready, grp_tag;
  logic [NG-1:0][W-1:0] grp_result;
  logic [NG-1:0][4:0] grp_status;
  logic [W-1:0] result;
  logic [4:0] status;
  logic [3:0] inflight;

  fpnew_opgroup_dispatch #(.NumOpGroups(NG), .Width(W), .MaxInFlight(MIF), .TagType(logic)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opgrp_i(opgrp), .grp_in_valid_o(grp_in_valid), .grp_in_ready_i(grp_in_ready),
    .grp_out_valid_i(grp_out_valid), .grp_out_ready_o(grp_out_ready), .grp_result_i(grp_result),
    .grp_status_i(grp_status), .grp_tag_i(grp_tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .status_o(status), .tag_o(tag), .inflight_o(inflight), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ord_q[$];        // issued op ids, oldest first
  int gq[NG][$];       // op ids pending inside each group
  int opg[8192];       // group each op id went to
  int pop_log[$];
  int next_id = 1;
  logic [NG-1:0] gv;   // group has finished its oldest op

  function automatic logic [63:0] pay_res(input int id);
    return {32'(id) ^ 32'hDEAD_BEEF, 32'(id)};
  endfunction
  function automatic logic [4:0] pay_st(input int id);
    return 5'(id * 7 + 3);
  endfunction
  function automatic logic pay_tag(input int id);
    return 1'(id & 1);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    ord_q.delete();
    for (int g = 0; g < NG; g++) gq[g].delete();
    gv = '0;
  endtask

  task automatic drive_groups();
    for (int g = 0; g < NG; g++) begin
      grp_out_valid[g] = gv[g] && gq[g].size() > 0;
      grp_result[g] = (gq[g].size() > 0) ? pay_res(gq[g][0]) : '0;
      grp_status[g] = (gq[g].size() > 0) ? pay_st(gq[g][0]) : '0;
      grp_tag[g]    = (gq[g].size() > 0) ? pay_tag(gq[g][0]) : 1'b0;
    end
  endtask

  // Called just after a falling edge with inputs set; ends at the next falling edge.
  task automatic step();
    logic [NG-1:0] egiv, egor;
    logic eir, eov, full;
    int hid, hg;
    drive_groups();
    #1;
    full = (ord_q.size() == MIF);
    egiv = '0;
    egor = '0;
    if (in_valid && !full && !flush) egiv[opgrp] = 1'b1;
    eir = in_valid && !full && !flush && grp_in_ready[opgrp];
    eov = 1'b0;
    hid = 0;
    hg = 0;
    if (ord_q.size() > 0) begin
      hid = ord_q[0];
      hg = opg[hid];
      eov = grp_out_valid[hg];
      if (out_ready) egor[hg] = 1'b1;
    end
    check("in_ready", in_ready, eir);
    check("grp_in_valid", grp_in_valid, egiv);
    check("out_valid", out_valid, eov);
    check("grp_out_ready", grp_out_ready, egor);
    check("result", result, eov ? pay_res(hid) : 64'd0);
    check("status", status, eov ? pay_st(hid) : 5'd0);
    check("tag", tag, eov ? pay_tag(hid) : 1'b0);
    @(posedge clk);
    if (flush) clear_model();
    else begin
      if (eov && out_ready) begin
        void'(ord_q.pop_front());
        void'(gq[hg].pop_front());
        gv[hg] = 1'b0;
        pop_log.push_back(hid);
      end
      if (eir) begin
        opg[next_id] = opgrp;
        ord_q.push_back(next_id);
        gq[opgrp].push_back(next_id);
        next_id++;
      end
    end
    @(negedge clk);
    check("inflight", inflight, ord_q.size());
    check("busy", busy, ord_q.size() != 0);
  endtask

  initial begin
    int base;
    logic [W-1:0] held;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; opgrp = '0; out_ready = 1'b0;
    grp_in_ready = '1; gv = '0;
    drive_groups();
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_inflight", inflight, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_grp_out_ready", grp_out_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reorder: grp2 then grp0, grp0 finishes first but must wait
    pop_log.delete();
    base = next_id;
    out_ready = 1'b1;
    in_valid = 1'b1; opgrp = 2; step();
    opgrp = 0; step();
    in_valid = 1'b0; gv[0] = 1'b1;
    repeat (3) begin
      step();
      check("reorder_hold0", grp_out_ready[0], 0);
    end
    gv[2] = 1'b1; step(); step();
    check("reorder_count", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      check("reorder_first", pop_log[0], base);
      check("reorder_second", pop_log[1], base + 1);
    end

    // Full: 8 issues to grp1, 9th blocked, pop in same cycle does not unblock it
    gv = '0; out_ready = 1'b0; in_valid = 1'b1; opgrp = 1;
    repeat (8) step();
    check("full_inflight8", inflight, 8);
    step();
    check("full_block", in_ready, 0);
    gv[1] = 1'b1; out_ready = 1'b1; step();
    check("full_inflight7", inflight, 7);
    out_ready = 1'b0; step();
    check("full_inflight8b", inflight, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) begin gv[1] = 1'b1; step(); end
    check("full_drained", inflight, 0);

    // Wrap: 20 issue+retire pairs
    pop_log.delete();
    base = next_id;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; opgrp = 2'($urandom_range(0, 3)); gv = '1;
      step();
      check("wrap_inflight_le1", inflight <= 1, 1);
    end
    in_valid = 1'b0; gv = '1; step();
    check("wrap_count", pop_log.size(), 20);
    for (int i = 0; i < pop_log.size(); i++) check("wrap_order", pop_log[i], base + i);

    // Backpressure: head valid, out_ready low
    in_valid = 1'b1; opgrp = 3; out_ready = 1'b0; step();
    in_valid = 1'b0; gv[3] = 1'b1; step();
    held = result;
    repeat (5) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_stable", result, held);
      check("bp_no_ack", grp_out_ready, 0);
    end
    out_ready = 1'b1; step();
    check("bp_drained", inflight, 0);

    // Flush with 3 in flight
    gv = '0; out_ready = 1'b0; in_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin opgrp = 2'(g); step(); end
    check("flush_pre", inflight, 3);
    opgrp = 3; flush = 1'b1; step();
    check("flush_inflight", inflight, 0);
    check("flush_busy", busy, 0);
    flush = 1'b0; in_valid = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      opgrp = 2'($urandom_range(0, 3));
      grp_in_ready = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      gv = gv | 4'($urandom);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; grp_in_ready = '1;
    repeat (12) begin gv = '1; step(); end
    check("random_drained", inflight, 0);

    // Async reset mid-traffic
    in_valid = 1'b1; opgrp = 0; step();
    in_valid = 1'b0; gv[0] = 1'b1; out_ready = 1'b0; step();
    check("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_inflight", inflight, 0);
    check("async_rst_busy", busy, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; opgrp = 1; step();
    in_valid = 1'b0; gv = '1; out_ready = 1'b1; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
